// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Imported by the next-PC mux and the PC control FSM.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    PEND,
    FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_PD,
    SRC_BR,
    SRC_EX
  } redir_src_t;

  localparam logic [31:0] RESET_PC_DEF   = 32'h1c00_0000;
  localparam logic [5:0]  ECODE_ADEF_DEF = 6'h08;
  localparam logic [7:0]  ECODE_NONE     = 8'h00;

  function automatic logic misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_npc_mux.sv
// Next-PC source selection: priority redirect target and
// BPU-or-sequential advance for the current fetch pair.
module npc_mux
  import fetch_pkg::*;
(
  input  logic        ex_redirect,
  input  logic [31:0] ex_pc,
  input  logic        br_flush,
  input  logic [31:0] br_pc,
  input  logic        pd_redirect,
  input  logic [31:0] pd_pc,
  input  logic        bpu_taken,
  input  logic [31:0] bpu_pc,
  input  logic [31:0] pc,
  output logic        redir,
  output logic [31:0] tgt,
  output logic [31:0] npc
);

  redir_src_t  src;
  logic [31:0] seq;

  assign redir = ex_redirect | br_flush | pd_redirect;

  always_comb begin
    src = SRC_PD;
    priority case (1'b1)
      ex_redirect: src = SRC_EX;
      br_flush:    src = SRC_BR;
      default:     src = SRC_PD;
    endcase
  end

  always_comb begin
    tgt = pd_pc;
    unique case (src)
      SRC_EX:  tgt = ex_pc;
      SRC_BR:  tgt = br_pc;
      default: tgt = pd_pc;
    endcase
  end

  // A pair never straddles an 8-byte block: odd-word PCs step by 4.
  assign seq = pc + (pc[2] ? 32'd4 : 32'd8);
  assign npc = bpu_taken ? bpu_pc : seq;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: owns the fetch PC, arbitrates redirects,
// holds redirects across stalls and flags misaligned fetch.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [5:0]  ECODE_ADEF = ECODE_ADEF_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_ex_redirect,
  input  logic [31:0] i_ex_pc,
  input  logic        flush_BR,
  input  logic [31:0] i_br_pc,
  input  logic        BR_predecoder,
  input  logic [31:0] i_pd_pc,
  input  logic        i_bpu_taken,
  input  logic [31:0] i_bpu_pc,
  input  logic        stall_ICache,
  input  logic        stall_full_instr,
  output logic [31:0] o_PC1,
  output logic [31:0] o_PC2,
  output logic        o_is_valid,
  output logic [7:0]  o_ecode
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_r, pc_nxt;
  logic [31:0]  pend_pc, pend_nxt;
  logic         stall;
  logic         redir;
  logic [31:0]  tgt;
  logic [31:0]  npc;

  assign stall = stall_ICache | stall_full_instr;

  npc_mux u_npc_mux (
    .ex_redirect (i_ex_redirect),
    .ex_pc       (i_ex_pc),
    .br_flush    (flush_BR),
    .br_pc       (i_br_pc),
    .pd_redirect (BR_predecoder),
    .pd_pc       (i_pd_pc),
    .bpu_taken   (i_bpu_taken),
    .bpu_pc      (i_bpu_pc),
    .pc          (pc_r),
    .redir       (redir),
    .tgt         (tgt),
    .npc         (npc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= BOOT;
      pc_r    <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pc_r    <= pc_nxt;
      pend_pc <= pend_nxt;
    end
  end

  // The youngest redirect seen while stalled always replaces the held one.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    pend_nxt  = pend_pc;
    unique case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (redir && !stall) begin
          pc_nxt    = tgt;
          state_nxt = misaligned(tgt) ? FAULT : FETCH;
        end else if (redir) begin
          pend_nxt  = tgt;
          state_nxt = PEND;
        end else if (!stall) begin
          pc_nxt    = npc;
          state_nxt = misaligned(npc) ? FAULT : FETCH;
        end
      end
      PEND: begin
        if (!stall) begin
          pc_nxt    = redir ? tgt : pend_pc;
          state_nxt = misaligned(pc_nxt) ? FAULT : FETCH;
        end else if (redir) begin
          pend_nxt = tgt;
        end
      end
      FAULT: begin
        if (redir && !stall) begin
          pc_nxt    = tgt;
          state_nxt = misaligned(tgt) ? FAULT : FETCH;
        end else if (redir) begin
          pend_nxt  = tgt;
          state_nxt = PEND;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_comb begin
    o_PC1      = pc_r;
    o_PC2      = pc_r + 32'd4;
    o_is_valid = 1'b0;
    o_ecode    = ECODE_NONE;
    unique case (state)
      FETCH: o_is_valid = 1'b1;
      FAULT: begin
        o_is_valid = 1'b1;
        o_ecode    = {1'b1, 1'b0, ECODE_ADEF};
      end
      default: o_is_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for the fetch PC sequencer.
// Each scenario task drives inputs and checks outputs inline.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rstn;
  logic        i_ex_redirect;
  logic [31:0] i_ex_pc;
  logic        flush_BR;
  logic [31:0] i_br_pc;
  logic        BR_predecoder;
  logic [31:0] i_pd_pc;
  logic        i_bpu_taken;
  logic [31:0] i_bpu_pc;
  logic        stall_ICache;
  logic        stall_full_instr;
  logic [31:0] o_PC1;
  logic [31:0] o_PC2;
  logic        o_is_valid;
  logic [7:0]  o_ecode;

  int checks = 0;
  int errors = 0;

  fetch_pc_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_ex_redirect    (i_ex_redirect),
    .i_ex_pc          (i_ex_pc),
    .flush_BR         (flush_BR),
    .i_br_pc          (i_br_pc),
    .BR_predecoder    (BR_predecoder),
    .i_pd_pc          (i_pd_pc),
    .i_bpu_taken      (i_bpu_taken),
    .i_bpu_pc         (i_bpu_pc),
    .stall_ICache     (stall_ICache),
    .stall_full_instr (stall_full_instr),
    .o_PC1            (o_PC1),
    .o_PC2            (o_PC2),
    .o_is_valid       (o_is_valid),
    .o_ecode          (o_ecode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    i_ex_redirect    = 1'b0;
    i_ex_pc          = '0;
    flush_BR         = 1'b0;
    i_br_pc          = '0;
    BR_predecoder    = 1'b0;
    i_pd_pc          = '0;
    i_bpu_taken      = 1'b0;
    i_bpu_pc         = '0;
    stall_ICache     = 1'b0;
    stall_full_instr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clr_in();
    tick();
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0000 || o_PC2 !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL rst_pc: got %h/%h want 1c000000/1c000004", o_PC1, o_PC2);
    end
    checks++;
    if (o_is_valid !== 1'b0 || o_ecode !== 8'h00) begin
      errors++;
      $display("FAIL rst_flags: got v=%b e=%h want 0/00", o_is_valid, o_ecode);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (o_is_valid !== 1'b1 || o_PC1 !== 32'h1c00_0000) begin
      errors++;
      $display("FAIL boot_exit: got v=%b pc=%h want 1/1c000000", o_is_valid, o_PC1);
    end
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0008) begin
      errors++;
      $display("FAIL seq8_a: got %h want 1c000008", o_PC1);
    end
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0010) begin
      errors++;
      $display("FAIL seq8_b: got %h want 1c000010", o_PC1);
    end
  endtask

  task automatic test_step4_and_br();
    i_bpu_taken = 1'b1;
    i_bpu_pc    = 32'h1c00_0004;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'h1c00_0004 || o_PC2 !== 32'h1c00_0008) begin
      errors++;
      $display("FAIL bpu_tgt: got %h/%h want 1c000004/1c000008", o_PC1, o_PC2);
    end
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0008) begin
      errors++;
      $display("FAIL seq4: got %h want 1c000008", o_PC1);
    end
    flush_BR    = 1'b1;
    i_br_pc     = 32'h1c00_0100;
    i_bpu_taken = 1'b1;
    i_bpu_pc    = 32'h1c00_0200;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'h1c00_0100 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL br_over_bpu: got %h v=%b want 1c000100/1", o_PC1, o_is_valid);
    end
  endtask

  task automatic test_pend_youngest();
    stall_ICache  = 1'b1;
    BR_predecoder = 1'b1;
    i_pd_pc       = 32'h1c00_0040;
    tick();
    checks++;
    if (o_is_valid !== 1'b0 || o_PC1 !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL pend1: got v=%b pc=%h want 0/1c000100", o_is_valid, o_PC1);
    end
    BR_predecoder = 1'b0;
    flush_BR      = 1'b1;
    i_br_pc       = 32'h1c00_0080;
    tick();
    checks++;
    if (o_is_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend2: got v=%b want 0", o_is_valid);
    end
    flush_BR = 1'b0;
    tick();
    checks++;
    if (o_is_valid !== 1'b0 || o_PC1 !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL pend3: got v=%b pc=%h want 0/1c000100", o_is_valid, o_PC1);
    end
    stall_ICache = 1'b0;
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0080 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_apply: got %h v=%b want 1c000080/1", o_PC1, o_is_valid);
    end
  endtask

  task automatic test_ex_on_release();
    stall_full_instr = 1'b1;
    flush_BR         = 1'b1;
    i_br_pc          = 32'h1c00_0300;
    tick();
    clr_in();
    checks++;
    if (o_is_valid !== 1'b0) begin
      errors++;
      $display("FAIL ibuf_pend: got v=%b want 0", o_is_valid);
    end
    i_ex_redirect = 1'b1;
    i_ex_pc       = 32'h1c00_0c00;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'h1c00_0c00 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL ex_release: got %h v=%b want 1c000c00/1", o_PC1, o_is_valid);
    end
  endtask

  task automatic test_fault();
    flush_BR = 1'b1;
    i_br_pc  = 32'h1c00_0102;
    tick();
    clr_in();
    i_bpu_taken = 1'b1;
    i_bpu_pc    = 32'h1c00_0400;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_PC1 !== 32'h1c00_0102 || o_ecode !== 8'h88 || o_is_valid !== 1'b1) begin
        errors++;
        $display("FAIL fault_hold%0d: got %h e=%h v=%b want 1c000102/88/1",
                 i, o_PC1, o_ecode, o_is_valid);
      end
      tick();
    end
    clr_in();
    i_ex_redirect = 1'b1;
    i_ex_pc       = 32'h1c00_0c00;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'h1c00_0c00 || o_ecode !== 8'h00) begin
      errors++;
      $display("FAIL fault_exit: got %h e=%h want 1c000c00/00", o_PC1, o_ecode);
    end
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0c08 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL fault_resume: got %h v=%b want 1c000c08/1", o_PC1, o_is_valid);
    end
  endtask

  task automatic test_priority();
    i_ex_redirect = 1'b1;
    i_ex_pc       = 32'h1c00_1000;
    flush_BR      = 1'b1;
    i_br_pc       = 32'h1c00_2000;
    BR_predecoder = 1'b1;
    i_pd_pc       = 32'h1c00_3000;
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_1000) begin
      errors++;
      $display("FAIL prio_ex: got %h want 1c001000", o_PC1);
    end
    i_ex_redirect = 1'b0;
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_2000) begin
      errors++;
      $display("FAIL prio_br: got %h want 1c002000", o_PC1);
    end
    flush_BR = 1'b0;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'h1c00_3000) begin
      errors++;
      $display("FAIL prio_pd: got %h want 1c003000", o_PC1);
    end
  endtask

  task automatic test_wrap_and_reset();
    i_bpu_taken = 1'b1;
    i_bpu_pc    = 32'hffff_fff8;
    tick();
    clr_in();
    checks++;
    if (o_PC1 !== 32'hffff_fff8 || o_PC2 !== 32'hffff_fffc) begin
      errors++;
      $display("FAIL wrap_pre: got %h/%h want fffffff8/fffffffc", o_PC1, o_PC2);
    end
    tick();
    checks++;
    if (o_PC1 !== 32'h0000_0000 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got %h v=%b want 00000000/1", o_PC1, o_is_valid);
    end
    stall_ICache = 1'b1;
    flush_BR     = 1'b1;
    i_br_pc      = 32'h1c00_0500;
    tick();
    flush_BR = 1'b0;
    checks++;
    if (o_is_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pend: got v=%b want 0", o_is_valid);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0000 || o_is_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_rst: got %h v=%b want 1c000000/0", o_PC1, o_is_valid);
    end
    rstn = 1'b1;
    clr_in();
    tick();
    checks++;
    if (o_PC1 !== 32'h1c00_0000 || o_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_discard: got %h v=%b want 1c000000/1", o_PC1, o_is_valid);
    end
  endtask

  initial begin
    rstn = 1'b0;
    clr_in();
    test_reset();
    test_step4_and_br();
    test_pend_youngest();
    test_ex_on_release();
    test_fault();
    test_priority();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
